// File: rtl/dcache_dm_if.sv
// Core data-port and RAM-port bundle for the direct-mapped cache.
// slave is the cache's view; master is the core/RAM side.
interface dcache_dm_if;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  modport slave (
    input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata, ram_rdata, ram_ack,
    output cpu_rdata, cpu_stall, ram_cs, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_ren, cpu_wen, cpu_addr, cpu_wdata, ram_rdata, ram_ack,
    input  cpu_rdata, cpu_stall, ram_cs, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with
// same-cycle read hits and hit/miss performance counters.
module dcache_dm #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  dcache_dm_if.slave       bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_data [LINES*LINE_WORDS];
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINES-1:0]  r_valid;
  logic [OFF_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_last;
  logic              w_lookup;
  logic              w_unused_addr;

  assign w_off         = bus.cpu_addr[OFF_W+1:2];
  assign w_idx         = bus.cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag         = bus.cpu_addr[31:OFF_W+IDX_W+2];
  assign w_hit         = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_last        = &r_cnt;
  assign w_lookup      = (r_state == ST_IDLE) & bus.cpu_ren & ~bus.cpu_wen;
  assign w_unused_addr = ^bus.cpu_addr[1:0];
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;

  always_comb begin
    w_state_nxt   = r_state;
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = 32'd0;
    bus.ram_cs    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = 32'd0;
    bus.ram_wdata = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_wen) begin
          bus.cpu_stall = 1'b1;
          w_state_nxt   = ST_WRITE;
        end else if (bus.cpu_ren) begin
          if (w_hit) begin
            bus.cpu_rdata = r_data[{w_idx, w_off}];
          end else begin
            bus.cpu_stall = 1'b1;
            w_state_nxt   = ST_FILL;
          end
        end else begin
          bus.cpu_stall = 1'b0;
        end
      end
      ST_FILL: begin
        // Stall stays high on the last ack; the following IDLE cycle re-looks up.
        bus.cpu_stall = 1'b1;
        bus.ram_cs    = 1'b1;
        bus.ram_addr  = {w_tag, w_idx, r_cnt, 2'b00};
        if (bus.ram_ack && w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_WRITE: begin
        bus.cpu_stall = ~bus.ram_ack;
        bus.ram_cs    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = {bus.cpu_addr[31:2], 2'b00};
        bus.ram_wdata = bus.cpu_wdata;
        if (bus.ram_ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control state, valid bits and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_valid    <= '0;
      r_cnt      <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lookup && w_hit) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end else if (w_lookup) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        r_cnt      <= '0;
      end else if (r_state == ST_FILL && bus.ram_ack) begin
        r_cnt <= r_cnt + OFF_W'(1);
        if (w_last) begin
          r_valid[w_idx] <= 1'b1;
        end
      end
    end
  end

  // Tag/data arrays are not reset; writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (rst && r_state == ST_FILL && bus.ram_ack) begin
      r_data[{w_idx, r_cnt}] <= bus.ram_rdata;
      if (w_last) begin
        r_tag[w_idx] <= w_tag;
      end
    end else if (rst && r_state == ST_WRITE && bus.ram_ack && w_hit) begin
      r_data[{w_idx, w_off}] <= bus.cpu_wdata;
    end
  end
endmodule
